// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer with one-shot done handshake or periodic auto-reload.
// Define DOWN_COUNTER_PRESCALE_EN to divide enabled edges by PRESCALE before each decrement.
module down_counter_timer #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    input  logic             auto_reload_i,
    input  logic             ack_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;
    logic             step;

`ifdef DOWN_COUNTER_PRESCALE_EN
    localparam int PS_W = $clog2(PRESCALE);
    logic [PS_W-1:0] ps_q, ps_d;
    assign step = (ps_q == PS_W'(PRESCALE - 1));
`else
    logic unused_prescale;
    assign unused_prescale = |PRESCALE;
    assign step = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
`ifdef DOWN_COUNTER_PRESCALE_EN
        ps_d     = ps_q;
`endif
        // Load overrides everything, including a coincident terminal edge or ack.
        if (load_i) begin
            count_d  = load_val_i;
            reload_d = load_val_i;
            state_d  = (load_val_i != '0) ? RUN : IDLE;
`ifdef DOWN_COUNTER_PRESCALE_EN
            ps_d     = '0;
`endif
        end else begin
            case (state_q)
                RUN: begin
                    if (en_i) begin
`ifdef DOWN_COUNTER_PRESCALE_EN
                        ps_d = step ? '0 : ps_q + PS_W'(1);
`endif
                        if (step) begin
                            if (count_q == WIDTH'(1)) begin
                                tc_d = 1'b1;
                                if (auto_reload_i) begin
                                    count_d = reload_q;
                                end else begin
                                    count_d = '0;
                                    state_d = DONE;
                                end
                            end else if (count_q != '0) begin
                                count_d = count_q - WIDTH'(1);
                            end
                        end
                    end
                end
                DONE: begin
                    count_d = '0;
                    if (ack_i) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // All state moves on the falling edge; outputs are registered from next-state.
    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
`ifdef DOWN_COUNTER_PRESCALE_EN
            ps_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
            busy_o   <= (state_d == RUN);
            done_o   <= (state_d == DONE);
`ifdef DOWN_COUNTER_PRESCALE_EN
            ps_q     <= ps_d;
`endif
        end
    end

    assign count_o = count_q;
    assign tc_o    = tc_q;

endmodule
